uart_tx_fifo: RTL and testbench

Byte buffer and strobe sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the system side into a small circular FIFO. It presents one byte at a time on tx_byte with a one-cycle stb pulse, and paces itself on the transmitter's rdy level. It runs on the same clk as the transmitter, i.e. baud x4.

---
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus strobe sequencer feeding the UART transmitter; paces pops on the transmitter's rdy level.
// Optional sticky overflow flag (ovf/ovf_clr ports) is built when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2      = 3,
  parameter int RESTROBE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            tx_byte,
  output logic                  stb,
`ifdef UART_TX_FIFO_OVF_EN
  output logic                  ovf,
  input  logic                  ovf_clr,
`endif
  input  logic                  rdy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int RC_W  = $clog2(RESTROBE_CYCLES);

  typedef enum logic [1:0] {IDLE, STRB, WBSY, WRDY} state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  stb_q, stb_d;
  logic [RC_W-1:0]       rcnt_q, rcnt_d;
  logic                  wr_accept;
  logic                  pop;

  // Flags are decoded from the registered count so nothing combinational leaks from wr_en/rdy.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign tx_byte   = tx_byte_q;
  assign stb       = stb_q;
  assign wr_accept = wr_en && !full;

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    stb_d     = 1'b0;
    rcnt_d    = rcnt_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && rdy) begin
          pop       = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          stb_d     = 1'b1;
          state_d   = STRB;
        end
      end
      STRB: begin
        rcnt_d  = '0;
        state_d = WBSY;
      end
      WBSY: begin
        // A transmitter that never leaves idle probably missed the strobe, so repeat it.
        if (!rdy) begin
          state_d = WRDY;
        end else if (rcnt_q == RC_W'(RESTROBE_CYCLES - 1)) begin
          stb_d   = 1'b1;
          state_d = STRB;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      WRDY: begin
        if (rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_accept ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_byte_q <= 8'h00;
      stb_q     <= 1'b0;
      rcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_byte_q <= tx_byte_d;
      stb_q     <= stb_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)        ovf_d = 1'b0;
    if (wr_en && full)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected strobed bytes, a negedge monitor checks them.
module tb_uart_tx_fifo;
  localparam int DEPTH_LOG2 = 3;
  localparam int RESTROBE   = 16;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty;
  logic [3:0] count;
  logic [7:0] tx_byte;
  logic       stb;
  logic       rdy;
  logic       rdyManual, rdyModel, txModelOn;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf;
  logic       ovf_clr;
`endif

  int         tests = 0;
  int         failures = 0;
  int         cycle = 0;
  int         stbTotal = 0;
  logic [7:0] expQ [$];
  logic [7:0] expByte;
  logic       prevStb;
  bit         modelBusy;
  int         sinceStb;

  assign rdy = txModelOn ? rdyModel : rdyManual;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .RESTROBE_CYCLES(RESTROBE)) dut (
    .clk     (clk),
    .res_n   (res_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .tx_byte (tx_byte),
    .stb     (stb),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
`endif
    .rdy     (rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor and transmitter model: rdy falls 4 clocks after a strobe and returns 40 clocks later.
  always @(negedge clk) begin
    if (!res_n) begin
      prevStb = 1'b0;
    end else begin
      if (stb === 1'b1) begin
        stbTotal++;
        checkOutput("strobe width", 32'(prevStb), 32'd0);
        if (expQ.size() == 0) begin
          tests++;
          failures++;
          $display("[TB] FAIL unexpected strobe: tx_byte %0h, no byte expected", tx_byte);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("tx_byte order", 32'(tx_byte), 32'(expByte));
        end
        if (txModelOn) begin
          checkOutput("strobe inside busy window", 32'(modelBusy), 32'd0);
          modelBusy = 1'b1;
          sinceStb  = 0;
        end
      end
      if (txModelOn && modelBusy) begin
        sinceStb++;
        if (sinceStb == 4) rdyModel = 1'b0;
        if (sinceStb == 44) begin
          rdyModel  = 1'b1;
          modelBusy = 1'b0;
        end
      end
      prevStb = stb;
    end
  end

  task automatic applyStimulus(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic waitStb(input string name, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (stb === 1'b1) begin
        at = cycle;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      failures++;
      $display("[TB] FAIL %s: no strobe within 200 cycles", name);
    end
  endtask

  task automatic handshake(input string name);
    int at;
    rdyManual = 1'b1;
    waitStb(name, at);
    rdyManual = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int at;
    int writeEdge;
    int base;
    int stbAt [4];

    res_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    rdyManual = 1'b1;
    rdyModel  = 1'b1;
    txModelOn = 1'b0;
    modelBusy = 1'b0;
    sinceStb  = 0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset tx_byte", 32'(tx_byte), 32'h00);
    checkOutput("reset stb", 32'(stb), 32'd0);
    checkOutput("reset full", 32'(full), 32'd0);
    checkOutput("reset empty", 32'(empty), 32'd1);
    checkOutput("reset count", 32'(count), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
    checkOutput("reset ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);

    // Single byte latency with rdy held high.
    writeEdge = cycle + 1;
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5);
    waitStb("first strobe", at);
    checkOutput("first strobe latency", 32'(at), 32'(writeEdge + 1));
    @(negedge clk);
    checkOutput("strobe single cycle", 32'(stb), 32'd0);
    checkOutput("count after pop", 32'(count), 32'd0);
    checkOutput("empty after pop", 32'(empty), 32'd1);
    checkOutput("tx_byte held", 32'(tx_byte), 32'hA5);
    rdyManual = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Fill to full with the transmitter busy, then drop one write.
    for (int i = 1; i <= 8; i++) begin
      expQ.push_back(8'(i));
      applyStimulus(8'(i));
    end
    checkOutput("full at 8", 32'(full), 32'd1);
    checkOutput("count at 8", 32'(count), 32'd8);
    applyStimulus(8'hFF);
    checkOutput("count after dropped write", 32'(count), 32'd8);
    checkOutput("full after dropped write", 32'(full), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
    checkOutput("ovf set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checkOutput("ovf cleared", 32'(ovf), 32'd0);
`endif
    for (int i = 0; i < 8; i++) handshake("drain full fifo");
    checkOutput("empty after drain", 32'(empty), 32'd1);

    // Transmitter model paces three queued bytes.
    base      = stbTotal;
    txModelOn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(8'hB1 + 8'(i));
      applyStimulus(8'hB1 + 8'(i));
    end
    for (int i = 0; i < 400 && (stbTotal - base) < 3; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    checkOutput("paced strobe count", 32'(stbTotal - base), 32'd3);
    rdyManual = 1'b0;
    txModelOn = 1'b0;
    @(negedge clk);

    // Restrobe while rdy stays high.
    for (int i = 0; i < 4; i++) expQ.push_back(8'h3C);
    applyStimulus(8'h3C);
    rdyManual = 1'b1;
    for (int i = 0; i < 4; i++) waitStb("restrobe", stbAt[i]);
    rdyManual = 1'b0;
    for (int i = 1; i < 4; i++)
      checkOutput("restrobe period", 32'(stbAt[i] - stbAt[i-1]), 32'(RESTROBE + 1));
    @(negedge clk);
    base = stbTotal;
    repeat (40) @(negedge clk);
    checkOutput("restrobe stops", 32'(stbTotal - base), 32'd0);
    checkOutput("count during restrobe", 32'(count), 32'd0);

    // Twenty bytes with simultaneous write+pop cycles forcing pointer wrap.
    for (int i = 0; i < 6; i++) begin
      expQ.push_back(8'h10 + 8'(i));
      applyStimulus(8'h10 + 8'(i));
    end
    checkOutput("count after 6 writes", 32'(count), 32'd6);
    handshake("first interleaved pop");
    for (int i = 6; i < 20; i++) begin
      rdyManual = 1'b1;
      @(negedge clk);
      expQ.push_back(8'h10 + 8'(i));
      applyStimulus(8'h10 + 8'(i));
      checkOutput("write+pop strobe", 32'(stb), 32'd1);
      checkOutput("write+pop count", 32'(count), 32'd5);
      rdyManual = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) handshake("drain interleaved");
    checkOutput("empty after wrap", 32'(empty), 32'd1);

    // Reset during WBSY with bytes still queued.
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(8'hC1 + 8'(i));
      applyStimulus(8'hC1 + 8'(i));
    end
    rdyManual = 1'b1;
    waitStb("pre-reset strobe", at);
    @(negedge clk);
    @(negedge clk);
    checkOutput("count before reset", 32'(count), 32'd4);
    #2;
    res_n = 1'b0;
    #1;
    checkOutput("reset stb", 32'(stb), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset empty", 32'(empty), 32'd1);
    checkOutput("reset tx_byte", 32'(tx_byte), 32'h00);
    expQ.delete();
    @(negedge clk);
    res_n = 1'b1;
    base  = stbTotal;
    repeat (40) @(negedge clk);
    checkOutput("no strobe after reset", 32'(stbTotal - base), 32'd0);
    expQ.push_back(8'h5A);
    applyStimulus(8'h5A);
    waitStb("strobe after reset", at);
    rdyManual = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
